// File: rtl/note_sequencer.sv
// -----------------------------------------------------------------------------
// note_sequencer
// Song-playback controller. Walks a note ROM one entry at a time, holds each
// note for its stored number of beats and reports play/pause and end-of-song
// status.
//
// Optional build macro: NOTE_SEQUENCER_LOOP_EN
//   defined   -> after the last entry, wrap to entry 0 and keep playing
//   undefined -> after the last entry, stop in DONE until restart
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-low reset
//   play_pause  in   1-cycle pulse, toggles playing (ignored in DONE)
//   restart     in   1-cycle pulse, rewind to entry 0
//   beat        in   1-cycle tick from the beat generator
//   rom_addr    out  note ROM read address
//   rom_data    in   {note, duration}, valid 1 cycle after rom_addr
//   note_out    out  current note code (0 = rest)
//   note_valid  out  note_out is to be sounded
//   new_note    out  1-cycle pulse on the first cycle of a note
//   playing     out  1 = running, 0 = paused
//   song_done   out  high while stopped at end of song
// -----------------------------------------------------------------------------
module note_sequencer #(
   parameter int ADDR_W   = 5,
   parameter int NOTE_W   = 6,
   parameter int DUR_W    = 6,
   parameter int SONG_LEN = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    play_pause,
   input  logic                    restart,
   input  logic                    beat,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [NOTE_W+DUR_W-1:0] rom_data,
   output logic [NOTE_W-1:0]       note_out,
   output logic                    note_valid,
   output logic                    new_note,
   output logic                    playing,
   output logic                    song_done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_PLAY  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DUR_W-1:0]  DUR_ONE   = DUR_W'(1);
   localparam logic [DUR_W-1:0]  DUR_ZERO  = {DUR_W{1'b0}};

   state_t              r_state, w_state_nxt, w_end_state;
   logic [ADDR_W-1:0]   r_addr, w_addr_nxt, w_end_addr;
   logic [DUR_W-1:0]    r_dur_cnt, w_dur_nxt;
   logic [NOTE_W-1:0]   r_note, w_note_nxt;
   logic                r_playing, w_playing_nxt;
   logic                r_new_note, w_new_note_nxt;
   logic                r_note_valid, r_song_done;
   logic [NOTE_W-1:0]   w_rom_note;
   logic [DUR_W-1:0]    w_rom_dur;

   assign w_rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
   assign w_rom_dur  = rom_data[DUR_W-1:0];

   // Where playback goes once the current entry is finished (or skipped).
   always_comb begin
      w_end_state = S_FETCH;
      w_end_addr  = r_addr + ADDR_ONE;
      if (r_addr == LAST_ADDR) begin
`ifdef NOTE_SEQUENCER_LOOP_EN
         w_end_state = S_FETCH;
         w_end_addr  = ADDR_ZERO;
`else
         w_end_state = S_DONE;
         w_end_addr  = r_addr;
`endif
      end else begin
         w_end_state = S_FETCH;
         w_end_addr  = r_addr + ADDR_ONE;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_dur_nxt      = r_dur_cnt;
      w_note_nxt     = r_note;
      w_new_note_nxt = 1'b0;

      if (play_pause && (r_state != S_DONE)) begin
         w_playing_nxt = ~r_playing;
      end else begin
         w_playing_nxt = r_playing;
      end

      if (restart) begin
         // Restart uses the post-toggle playing value to pick its target.
         w_addr_nxt  = ADDR_ZERO;
         w_dur_nxt   = DUR_ZERO;
         w_state_nxt = w_playing_nxt ? S_FETCH : S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_playing) begin
                  w_state_nxt = S_FETCH;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_FETCH: begin
               w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
               w_note_nxt = w_rom_note;
               w_dur_nxt  = w_rom_dur;
               if (w_rom_dur == DUR_ZERO) begin
                  // Zero-length entry is skipped silently.
                  w_state_nxt = w_end_state;
                  w_addr_nxt  = w_end_addr;
               end else begin
                  w_state_nxt    = S_PLAY;
                  w_new_note_nxt = 1'b1;
               end
            end
            S_PLAY: begin
               // Beat counts only if we were playing before this edge.
               if (beat && r_playing) begin
                  if (r_dur_cnt > DUR_ONE) begin
                     w_dur_nxt = r_dur_cnt - DUR_ONE;
                  end else begin
                     w_state_nxt = w_end_state;
                     w_addr_nxt  = w_end_addr;
                  end
               end else begin
                  w_state_nxt = S_PLAY;
               end
            end
            S_DONE: begin
               w_state_nxt = S_DONE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State, datapath and registered output flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_addr       <= ADDR_ZERO;
         r_dur_cnt    <= DUR_ZERO;
         r_note       <= {NOTE_W{1'b0}};
         r_playing    <= 1'b0;
         r_new_note   <= 1'b0;
         r_note_valid <= 1'b0;
         r_song_done  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_addr       <= w_addr_nxt;
         r_dur_cnt    <= w_dur_nxt;
         r_note       <= w_note_nxt;
         r_playing    <= w_playing_nxt;
         r_new_note   <= w_new_note_nxt;
         r_note_valid <= (w_state_nxt == S_PLAY) && w_playing_nxt;
         r_song_done  <= (w_state_nxt == S_DONE);
      end
   end

   assign rom_addr   = r_addr;
   assign note_out   = r_note;
   assign note_valid = r_note_valid;
   assign new_note   = r_new_note;
   assign playing    = r_playing;
   assign song_done  = r_song_done;

endmodule

// File: tb/tb_note_sequencer.sv
module tb_note_sequencer;

   logic        clk;
   logic        rst;
   logic        play_pause;
   logic        restart;
   logic        beat;
   logic [4:0]  rom_addr;
   logic [11:0] rom_data;
   logic [5:0]  note_out;
   logic        note_valid;
   logic        new_note;
   logic        playing;
   logic        song_done;

   int n_tests;
   int n_fail;

   typedef struct {
      logic [5:0] note;
      logic [4:0] addr;
   } exp_t;
   exp_t exp_q[$];

   logic [11:0] rom [0:3];

   note_sequencer #(
      .ADDR_W(5), .NOTE_W(6), .DUR_W(6), .SONG_LEN(4)
   ) dut (
      .clk(clk), .rst(rst), .play_pause(play_pause), .restart(restart),
      .beat(beat), .rom_addr(rom_addr), .rom_data(rom_data),
      .note_out(note_out), .note_valid(note_valid), .new_note(new_note),
      .playing(playing), .song_done(song_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous ROM: data appears one cycle after the address.
   always @(posedge clk) rom_data <= rom[rom_addr[1:0]];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard monitor: every new_note pulse must match the next expected note.
   always @(negedge clk) begin
      if (rst && new_note) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_new_note: got note %0d addr %0d expected none", note_out, rom_addr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_note", 32'(note_out), 32'(e.note));
            check("sb_addr", 32'(rom_addr), 32'(e.addr));
            check("sb_valid", 32'(note_valid), 32'd1);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] n, input logic [4:0] a);
      exp_t e;
      e.note = n;
      e.addr = a;
      exp_q.push_back(e);
   endtask

   task automatic do_beat();
      beat = 1'b1;
      tick();
      beat = 1'b0;
   endtask

   task automatic do_pp();
      play_pause = 1'b1;
      tick();
      play_pause = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rom[0] = {6'd5, 6'd2};
      rom[1] = {6'd9, 6'd1};
      rom[2] = {6'd33, 6'd0};
      rom[3] = {6'd12, 6'd3};
      rst = 1'b0;
      play_pause = 1'b0;
      restart = 1'b0;
      beat = 1'b0;
      #1;
      check("rst_addr", 32'(rom_addr), 32'd0);
      check("rst_valid", 32'(note_valid), 32'd0);
      check("rst_done", 32'(song_done), 32'd0);
      check("rst_playing", 32'(playing), 32'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // First note: PLAY three cycles after the play pulse.
      do_pp();
      check("pp_playing", 32'(playing), 32'd1);
      push(6'd5, 5'd0);
      tick();
      tick();
      check("pre_play_valid", 32'(note_valid), 32'd0);
      tick();
      check("n0_note", 32'(note_out), 32'd5);
      check("n0_valid", 32'(note_valid), 32'd1);
      check("n0_new", 32'(new_note), 32'd1);
      tick();
      check("n0_new_pulse_end", 32'(new_note), 32'd0);

      // Two beats end the dur-2 note.
      do_beat();
      check("n0_after1_valid", 32'(note_valid), 32'd1);
      do_beat();
      check("n0_end_addr", 32'(rom_addr), 32'd1);
      check("n0_end_valid", 32'(note_valid), 32'd0);
      push(6'd9, 5'd1);
      tick();
      tick();
      check("n1_note", 32'(note_out), 32'd9);
      check("n1_valid", 32'(note_valid), 32'd1);

      // Entry 2 has zero duration and is skipped.
      do_beat();
      check("n1_end_addr", 32'(rom_addr), 32'd2);
      tick();
      tick();
      check("skip_addr", 32'(rom_addr), 32'd3);
      check("skip_valid", 32'(note_valid), 32'd0);
      check("skip_new", 32'(new_note), 32'd0);
      push(6'd12, 5'd3);
      tick();
      tick();
      check("n3_note", 32'(note_out), 32'd12);
      check("n3_valid", 32'(note_valid), 32'd1);

      // Pause after one beat of the dur-3 note; beats while paused are ignored.
      do_beat();
      do_pp();
      check("pause_playing", 32'(playing), 32'd0);
      check("pause_valid", 32'(note_valid), 32'd0);
      check("pause_note", 32'(note_out), 32'd12);
      for (int i = 0; i < 4; i++) begin
         do_beat();
         tick();
      end
      check("paused_addr", 32'(rom_addr), 32'd3);
      check("paused_valid", 32'(note_valid), 32'd0);

      // Resume with a simultaneous beat: that beat is not counted.
      play_pause = 1'b1;
      beat = 1'b1;
      tick();
      play_pause = 1'b0;
      beat = 1'b0;
      check("resume_valid", 32'(note_valid), 32'd1);
      check("resume_new", 32'(new_note), 32'd0);
      check("resume_note", 32'(note_out), 32'd12);
      do_beat();
      check("resume_b1_valid", 32'(note_valid), 32'd1);
      check("resume_b1_done", 32'(song_done), 32'd0);
      do_beat();
`ifdef NOTE_SEQUENCER_LOOP_EN
      check("loop_done", 32'(song_done), 32'd0);
      check("loop_addr", 32'(rom_addr), 32'd0);
      push(6'd5, 5'd0);
      tick();
      tick();
      check("loop_note", 32'(note_out), 32'd5);
      check("loop_valid", 32'(note_valid), 32'd1);
`else
      check("end_done", 32'(song_done), 32'd1);
      check("end_valid", 32'(note_valid), 32'd0);
      do_pp();
      check("done_pp_ignored", 32'(playing), 32'd1);
      check("done_stays", 32'(song_done), 32'd1);
`endif

      // Restart rewinds and resumes playback.
      restart = 1'b1;
      tick();
      restart = 1'b0;
      check("restart_addr", 32'(rom_addr), 32'd0);
      check("restart_done", 32'(song_done), 32'd0);
      push(6'd5, 5'd0);
      tick();
      tick();
      check("restart_note", 32'(note_out), 32'd5);
      check("restart_valid", 32'(note_valid), 32'd1);

      // Asynchronous reset in the middle of PLAY.
      tick();
      rst = 1'b0;
      #1;
      check("midrst_addr", 32'(rom_addr), 32'd0);
      check("midrst_note", 32'(note_out), 32'd0);
      check("midrst_valid", 32'(note_valid), 32'd0);
      check("midrst_playing", 32'(playing), 32'd0);
      tick();
      rst = 1'b1;
      tick();
      tick();
      tick();
      check("idle_valid", 32'(note_valid), 32'd0);
      check("idle_addr", 32'(rom_addr), 32'd0);

      // Restart and play_pause together: next state uses the new playing value.
      restart = 1'b1;
      play_pause = 1'b1;
      tick();
      restart = 1'b0;
      play_pause = 1'b0;
      check("rp_playing", 32'(playing), 32'd1);
      push(6'd5, 5'd0);
      tick();
      tick();
      check("rp_note", 32'(note_out), 32'd5);
      check("rp_valid", 32'(note_valid), 32'd1);
      tick();
      tick();

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
Song-playback controller for the beat-driven music datapath. Sequences through a note ROM one entry at a time and holds each note for its stored duration in beats, counting single-cycle beat ticks from the beat generator. Drives the current note to the note player and provides play/pause, restart and end-of-song status to the top-level UI.

Parameters:
ADDR_W, 5, width of ROM address / note index
NOTE_W, 6, width of note code (0 = rest)
DUR_W, 6, width of duration field, in beats
SONG_LEN, 32, number of ROM entries in the song (1..2^ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
play_pause  in  1  1-cycle pulse; toggles playing
restart  in  1  1-cycle pulse; rewind to entry 0
beat  in  1  1-cycle tick from beat generator
rom_addr  out  ADDR_W  note ROM read address
rom_data  in  NOTE_W+DUR_W  {note, duration}; valid 1 cycle after rom_addr
note_out  out  NOTE_W  current note to player
note_valid  out  1  note_out is to be sounded
new_note  out  1  1-cycle pulse when a new note starts
playing  out  1  1 = running, 0 = paused
song_done  out  1  high while in DONE

Behaviour:
- Reset (rst low, async): state IDLE, addr=0, dur_cnt=0, playing=0; all outputs 0 (rom_addr=0, note_out=0, note_valid=0, new_note=0, song_done=0).
- playing toggles on every play_pause pulse in any state except DONE (in DONE, play_pause ignored).
- rom_addr = addr register at all times.
- States:
  - IDLE: wait; when playing=1 -> FETCH.
  - FETCH: one cycle, ROM address presented -> LOAD.
  - LOAD: latch note_reg = rom_data[NOTE_W+DUR_W-1:DUR_W], dur_cnt = rom_data[DUR_W-1:0].
    - If duration==0: entry skipped, no new_note; advance as for end of note.
    - Otherwise -> PLAY.
  - PLAY: new_note=1 on first PLAY cycle only. On beat with playing=1:
    - dur_cnt>1: dur_cnt-=1.
    - dur_cnt==1: end of note; if addr==SONG_LEN-1 -> DONE, else addr+=1 -> FETCH.
  - DONE: note_valid=0, song_done=1; stays until restart.
- Latency: play_pause pulse at edge N -> playing=1 after N; FETCH after N+1, LOAD after N+2, PLAY with note_valid=1 and new_note=1 after N+3.
- Note of duration D ends on the D-th beat counted in PLAY. FETCH/LOAD take 2 cycles; beats arriving in IDLE, FETCH, LOAD or DONE are dropped (beat period >> 2 cycles).
- note_out = note_reg; note_valid = (state==PLAY) && playing.
- Pause: playing=0 in PLAY freezes dur_cnt and addr and drops note_valid; note_out is held. Resume continues the same note with the remaining count and does not pulse new_note.
- restart (any state): addr=0, dur_cnt=0, next state FETCH if playing else IDLE; song_done cleared next cycle.
- restart + play_pause in the same cycle: both apply; playing toggles and next state uses the new playing value.
- beat + play_pause in the same cycle in PLAY: beat is counted only if playing was 1 before the edge.
- addr arithmetic is modulo 2^ADDR_W; it never exceeds SONG_LEN-1.

Optional Feature:
LOOP_EN (macro NOTE_SEQUENCER_LOOP_EN):
- Defined: end of last entry sets addr=0 and goes to FETCH (continuous loop); DONE is unreachable and song_done stays 0.
- Undefined: behaviour as above (stop in DONE).

Test Plan:
- Reset mid-PLAY, rst low for 1 cycle -> all outputs 0 immediately; state IDLE, addr=0.
- ROM entry0={note 5, dur 2}, entry1={9,1}; play_pause -> 3 cycles later note_out=5, note_valid=1, new_note 1 cycle; after 2 beats rom_addr=1; 3 cycles later note_out=9.
- Pause after 1 beat of a dur-3 note, send 4 beats while paused -> note_valid=0, dur_cnt unchanged. Resume -> note_out unchanged, no new_note; note ends after 2 more beats.
- Entry with dur=0 between two notes -> skipped, no new_note for it; next entry plays 2 cycles later.
- SONG_LEN=4, play to end -> song_done=1, note_valid=0, play_pause ignored; restart -> rom_addr=0, song_done=0, playback resumes.
- With NOTE_SEQUENCER_LOOP_EN defined, SONG_LEN=4 -> after entry 3 ends, rom_addr=0 and new_note pulses for entry 0; song_done stays 0.
